// File: rtl/pwd_writer.sv
// Password enrollment controller: scans the stored table for a duplicate of the
// candidate and appends it at the next free address when it is new.
module pwd_writer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enter,
    input  logic              clr,
    input  logic [DATA_W-1:0] senha,
    input  logic [DATA_W-1:0] out_mem,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_mem,
    output logic              we,
    output logic              busy,
    output logic              done,
    output logic              dup,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_CMP   = 3'd2,
        S_WRITE = 3'd3,
        S_OK    = 3'd4,
        S_DUP   = 3'd5
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    state_t             state_q, state_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0]  cand_q, cand_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dup_q, dup_d;
    logic               full_q, full_d;

    // Next-state logic; outputs are decoded from the next state so they are registered.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        cand_d  = cand_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    count_d = {(ADDR_W+1){1'b0}};
                end else if (enter && !full_q) begin
                    cand_d = senha;
                    idx_d  = {ADDR_W{1'b0}};
                    if (count_q != {(ADDR_W+1){1'b0}}) begin
                        state_d = S_RD;
                        addr_d  = {ADDR_W{1'b0}};
                    end else begin
                        state_d = S_WRITE;
                        addr_d  = count_q[ADDR_W-1:0];
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                // idx stops at count-1, so it can never wrap past the table end
                if (out_mem == cand_q) begin
                    state_d = S_DUP;
                end else if ({1'b0, idx_q} == (count_q - CNT_ONE)) begin
                    state_d = S_WRITE;
                    addr_d  = count_q[ADDR_W-1:0];
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    addr_d  = idx_q + IDX_ONE;
                    state_d = S_RD;
                end
            end
            S_WRITE: begin
                count_d = count_q + CNT_ONE;
                state_d = S_OK;
            end
            S_OK: begin
                state_d = S_IDLE;
            end
            S_DUP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        we_d   = (state_d == S_WRITE);
        done_d = (state_d == S_OK);
        dup_d  = (state_d == S_DUP);
        busy_d = (state_d != S_IDLE);
        full_d = (count_d == DEPTH_C);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= {(ADDR_W+1){1'b0}};
            idx_q   <= {ADDR_W{1'b0}};
            cand_q  <= {DATA_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dup_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            cand_q  <= cand_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dup_q   <= dup_d;
            full_q  <= full_d;
        end
    end

    assign addr     = addr_q;
    assign data_mem = cand_q;
    assign we       = we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dup      = dup_q;
    assign full     = full_q;
    assign count    = count_q;

endmodule

// File: tb/tb_pwd_writer.sv
// Scoreboard bench for pwd_writer: a queue-based table model predicts each
// enrollment outcome and latency; a forked monitor checks every done/dup pulse.
module tb_pwd_writer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enter = 1'b0;
    logic              clr = 1'b0;
    logic [DATA_W-1:0] senha = 8'h00;
    logic [DATA_W-1:0] out_mem;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_mem;
    logic              we, busy, done, dup, full;
    logic [ADDR_W:0]   count;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    int cyc = 0;

    typedef struct {
        bit                is_dup;
        int                lat;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        int                start;
        int                we0;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] model[$];
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int we_cyc = 0;
    logic [ADDR_W-1:0] we_addr_l = '0;
    logic [DATA_W-1:0] we_data_l = '0;

    pwd_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enter(enter), .clr(clr), .senha(senha),
        .out_mem(out_mem), .addr(addr), .data_mem(data_mem), .we(we),
        .busy(busy), .done(done), .dup(dup), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: one-cycle read latency, write on we.
    always @(posedge clk) begin
        if (we) ram[addr] <= data_mem;
        out_mem <= ram[addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (we) begin
                we_cnt++;
                we_addr_l = addr;
                we_data_l = data_mem;
                we_cyc = cyc;
            end
            if (done || dup) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, done, dup}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("kind_dup", {31'd0, dup}, {31'd0, e.is_dup});
                    chk("latency", cyc - e.start, e.lat);
                    if (e.is_dup) begin
                        chk("dup_no_we", we_cnt - e.we0, 32'd0);
                    end else begin
                        chk("we_once", we_cnt - e.we0, 32'd1);
                        chk("we_cycle", we_cyc - e.start, e.lat - 1);
                        chk("waddr", {28'd0, we_addr_l}, {28'd0, e.waddr});
                        chk("wdata", {24'd0, we_data_l}, {24'd0, e.wdata});
                    end
                end
            end
        end
    endtask

    task automatic enroll(input logic [DATA_W-1:0] v);
        exp_t e;
        int   k;
        int   n;
        int   w0;
        bit   is_full;
        bit   finished;
        n = model.size();
        is_full = (n == DEPTH);
        k = -1;
        for (int i = 0; i < n; i++) if (k < 0 && model[i] == v) k = i;
        w0 = we_cnt;
        if (!is_full) begin
            e.is_dup = (k >= 0);
            e.lat    = (k >= 0) ? 2 * k + 3 : 2 * n + 2;
            e.waddr  = ADDR_W'(n);
            e.wdata  = v;
            e.start  = cyc;
            e.we0    = w0;
            exp_q.push_back(e);
        end
        enter = 1'b1;
        senha = v;
        @(negedge clk);
        enter = 1'b0;
        senha = 8'($urandom);
        if (is_full) begin
            chk("full_no_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk("full_no_we", we_cnt - w0, 32'd0);
        end else begin
            finished = 1'b0;
            for (int t = 0; t < 2 * DEPTH + 10 && !finished; t++) begin
                @(negedge clk);
                if (!busy) finished = 1'b1;
            end
            chk("busy_timeout", {31'd0, finished}, 32'd1);
            if (k < 0) model.push_back(v);
        end
        chk("count", {27'd0, count}, model.size());
        chk("full", {31'd0, full}, {31'd0, model.size() == DEPTH});
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model.delete();
        chk("clr_count", {27'd0, count}, 32'd0);
        chk("clr_full", {31'd0, full}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model.delete();
        exp_q.delete();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_pulses", {29'd0, we, done, dup}, 32'd0);
        chk("rst_addr", {28'd0, addr}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        @(negedge clk);
        do_reset();
        chk("rst_data_mem", {24'd0, data_mem}, 32'd0);

        enroll(8'hA5);

        do_clr();
        enroll(8'h11);
        enroll(8'h22);
        enroll(8'h33);
        enroll(8'h44);
        enroll(8'h22);

        // Random enrollments over a small value range so duplicates are common.
        for (int i = 0; i < 50; i++) enroll(8'($urandom_range(0, 31)));
        for (int i = 0; model.size() < DEPTH; i++) enroll(8'(8'h80 + i));
        enroll(8'h99);
        do_clr();

        // Reset in the middle of a scan discards the transaction.
        enroll(8'h11);
        enroll(8'h22);
        enroll(8'h33);
        enter = 1'b1;
        senha = 8'h44;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        chk("scan_busy", {31'd0, busy}, 32'd1);
        do_reset();
        repeat (3) @(negedge clk);
        enroll(8'h5A);

        // clr wins over a simultaneous enter.
        enroll(8'h6B);
        enter = 1'b1;
        clr = 1'b1;
        senha = 8'h77;
        @(negedge clk);
        enter = 1'b0;
        clr = 1'b0;
        model.delete();
        chk("clr_enter_busy", {31'd0, busy}, 32'd0);
        chk("clr_enter_count", {27'd0, count}, 32'd0);
        @(negedge clk);
        chk("clr_enter_idle", {31'd0, busy}, 32'd0);
        enroll(8'h77);

        repeat (4) @(negedge clk);
        chk("leftover_expect", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
